uart_rx: RTL and testbench

- Oversampling UART receiver; the receive end of the transmitter used in top.
- Shares the same s_tick oversampling strobe and DBIT framing as the transmitter.
- Deserialises 8N1-style frames, LSB first, from the rx line.
- Presents each received byte on dout with a one-cycle rx_done_tick, or flags a framing error.

---
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop line synchroniser feeding a start/data/stop FSM.
// Samples each bit at its midpoint using the shared s_tick strobe; LSB first.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            rx_frame_err,
    output logic            rx_busy
);

    // state | meaning
    // IDLE  | line idle, waiting for a low level on rx_s
    // START | counting to the middle of the start bit
    // DATA  | sampling DBIT data bits at their midpoints
    // STOP  | counting SB_TICK ticks, then checking the stop level

    localparam int SMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID_START = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_MID_DATA  = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP_END  = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_s;
    logic [NW-1:0]   r_n;
    logic [DBIT-1:0] r_sr;
    logic [DBIT-1:0] r_dout;
    logic            r_done;
    logic            r_err;
    logic            r_sync1;
    logic            r_rx_s;

    // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_sr    <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= START;
                        r_s     <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (r_s == S_MID_START) begin
                            if (!r_rx_s) begin
                                r_state <= DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (r_s == S_MID_DATA) begin
                            r_s  <= '0;
                            r_sr <= {r_rx_s, r_sr[DBIT-1:1]};
                            if (r_n == N_LAST) begin
                                r_state <= STOP;
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (r_s == S_STOP_END) begin
                            r_state <= IDLE;
                            if (r_rx_s) begin
                                r_dout <= r_sr;
                                r_done <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign rx_frame_err = r_err;
    assign rx_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OS=16, SB_TICK=16, DBIT=8, s_tick every 4 clk (64 clk per bit).
// Each scenario task drives the line and compares outputs against hand-computed values.
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       s_tick;
    logic       rx;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       rx_frame_err;
    logic       rx_busy;

    int vectors;
    int miscompares;

    int         done_cnt;
    int         err_cnt;
    int         both_cnt;
    int         long_pulse_cnt;
    logic [7:0] rx_q[$];

    uart_rx #(.DBIT(8), .OS(16), .SB_TICK(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tick       (s_tick),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int div;
        div    = 0;
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            div    = (div + 1) % 4;
            s_tick = (div == 0);
        end
    end

    // Records pulses; all judgements happen in the scenario tasks.
    initial begin
        logic prev_done;
        logic prev_err;
        prev_done      = 1'b0;
        prev_err       = 1'b0;
        done_cnt       = 0;
        err_cnt        = 0;
        both_cnt       = 0;
        long_pulse_cnt = 0;
        forever begin
            @(negedge clk);
            if (rx_done_tick === 1'b1) begin
                done_cnt++;
                rx_q.push_back(dout);
            end
            if (rx_frame_err === 1'b1) err_cnt++;
            if (rx_done_tick === 1'b1 && rx_frame_err === 1'b1) both_cnt++;
            if ((prev_done && rx_done_tick === 1'b1) || (prev_err && rx_frame_err === 1'b1))
                long_pulse_cnt++;
            prev_done = (rx_done_tick === 1'b1);
            prev_err  = (rx_frame_err === 1'b1);
        end
    end

    task automatic drive_line(input logic val, input int nclk);
        rx = val;
        repeat (nclk) @(negedge clk);
    endtask

    // A low stop bit is held for 48 clk only, so the receiver's immediate re-arm
    // sees a high line at its mid-start check and does not start a phantom frame.
    task automatic send_frame(input logic [7:0] data, input int bclk, input logic stop_ok);
        drive_line(1'b0, bclk);
        for (int i = 0; i < 8; i++) drive_line(data[i], bclk);
        if (stop_ok) begin
            drive_line(1'b1, bclk);
        end else begin
            drive_line(1'b0, 48);
            drive_line(1'b1, bclk - 48);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (dout !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_dout: got %h expected %h", dout, 8'h00);
        end
        vectors++;
        if (rx_done_tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b expected 0", rx_done_tick);
        end
        vectors++;
        if (rx_frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b expected 0", rx_frame_err);
        end
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy: got %b expected 0", rx_busy);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_single_a5;
        int d0, e0, busy_low, budget;
        d0       = done_cnt;
        e0       = err_cnt;
        busy_low = 0;
        fork
            send_frame(8'hA5, 64, 1'b1);
            begin
                repeat (8) @(negedge clk);
                budget = 800;
                while (rx_done_tick !== 1'b1 && budget > 0) begin
                    if (rx_busy !== 1'b1) busy_low++;
                    budget--;
                    @(negedge clk);
                end
                vectors++;
                if (budget == 0) begin
                    miscompares++;
                    $display("FAIL a5_done_timeout: got no pulse expected pulse within 800 clk");
                end
            end
        join
        repeat (20) @(negedge clk);
        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL a5_done_count: got %0d expected 1", done_cnt - d0);
        end
        vectors++;
        if (dout !== 8'hA5) begin
            miscompares++;
            $display("FAIL a5_dout: got %h expected %h", dout, 8'hA5);
        end
        vectors++;
        if (err_cnt - e0 != 0) begin
            miscompares++;
            $display("FAIL a5_err_count: got %0d expected 0", err_cnt - e0);
        end
        vectors++;
        if (busy_low != 0) begin
            miscompares++;
            $display("FAIL a5_busy_gap: got %0d low cycles expected 0", busy_low);
        end
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL a5_busy_after: got %b expected 0", rx_busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_bytes[3];
        int e0;
        exp_bytes[0] = 8'h00;
        exp_bytes[1] = 8'hFF;
        exp_bytes[2] = 8'h3C;
        e0 = err_cnt;
        rx_q.delete();
        for (int i = 0; i < 3; i++) send_frame(exp_bytes[i], 64, 1'b1);
        repeat (20) @(negedge clk);
        vectors++;
        if (rx_q.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d expected 3", rx_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (rx_q.size() <= i) begin
                miscompares++;
                $display("FAIL b2b_byte%0d: got none expected %h", i, exp_bytes[i]);
            end else if (rx_q[i] !== exp_bytes[i]) begin
                miscompares++;
                $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[i], exp_bytes[i]);
            end
        end
        vectors++;
        if (err_cnt - e0 != 0) begin
            miscompares++;
            $display("FAIL b2b_err_count: got %0d expected 0", err_cnt - e0);
        end
        vectors++;
        if (dout !== 8'h3C) begin
            miscompares++;
            $display("FAIL b2b_dout: got %h expected %h", dout, 8'h3C);
        end
    endtask

    task automatic test_glitch;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        drive_line(1'b0, 10);
        vectors++;
        if (rx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy_start: got %b expected 1", rx_busy);
        end
        drive_line(1'b0, 10);
        drive_line(1'b1, 20);
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_busy_40clk: got %b expected 0", rx_busy);
        end
        repeat (700) @(negedge clk);
        vectors++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin
            miscompares++;
            $display("FAIL glitch_pulses: got done %0d err %0d expected 0 0",
                     done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_frame_err;
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h55, 64, 1'b0);
        repeat (100) @(negedge clk);
        vectors++;
        if (err_cnt - e0 != 1) begin
            miscompares++;
            $display("FAIL ferr_err_count: got %0d expected 1", err_cnt - e0);
        end
        vectors++;
        if (done_cnt - d0 != 0) begin
            miscompares++;
            $display("FAIL ferr_done_count: got %0d expected 0", done_cnt - d0);
        end
        vectors++;
        if (dout !== 8'h3C) begin
            miscompares++;
            $display("FAIL ferr_dout: got %h expected %h", dout, 8'h3C);
        end
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ferr_busy: got %b expected 0", rx_busy);
        end
    endtask

    task automatic test_reset_midframe;
        int d0, e0;
        logic [7:0] b;
        b  = 8'h81;
        d0 = done_cnt;
        e0 = err_cnt;
        drive_line(1'b0, 64);
        for (int i = 0; i < 4; i++) drive_line(b[i], 64);
        drive_line(b[4], 32);
        vectors++;
        if (rx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_busy_before: got %b expected 1", rx_busy);
        end
        // Abort the transmission together with the reset so the line returns to idle.
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({dout, rx_done_tick, rx_frame_err, rx_busy} !== 11'b0) begin
            miscompares++;
            $display("FAIL rstmid_outputs: got dout %h done %b err %b busy %b expected all 0",
                     dout, rx_done_tick, rx_frame_err, rx_busy);
        end
        repeat (100) @(negedge clk);
        vectors++;
        if (done_cnt - d0 != 0 || err_cnt - e0 != 0) begin
            miscompares++;
            $display("FAIL rstmid_pulses: got done %0d err %0d expected 0 0",
                     done_cnt - d0, err_cnt - e0);
        end
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(8'h81, 64, 1'b1);
        repeat (20) @(negedge clk);
        vectors++;
        if (done_cnt - d0 != 1 || dout !== 8'h81 || err_cnt - e0 != 0) begin
            miscompares++;
            $display("FAIL rstmid_recover: got done %0d dout %h err %0d expected 1 81 0",
                     done_cnt - d0, dout, err_cnt - e0);
        end
    endtask

    task automatic test_baud_tolerance;
        int periods[2];
        int d0, e0;
        periods[0] = 62;
        periods[1] = 66;
        for (int k = 0; k < 2; k++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            send_frame(8'hC3, periods[k], 1'b1);
            repeat (40) @(negedge clk);
            vectors++;
            if (done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
                miscompares++;
                $display("FAIL baud%0d_pulses: got done %0d err %0d expected 1 0",
                         periods[k], done_cnt - d0, err_cnt - e0);
            end
            vectors++;
            if (dout !== 8'hC3) begin
                miscompares++;
                $display("FAIL baud%0d_dout: got %h expected %h", periods[k], dout, 8'hC3);
            end
        end
    endtask

    task automatic test_pulse_shape;
        vectors++;
        if (both_cnt != 0 || long_pulse_cnt != 0) begin
            miscompares++;
            $display("FAIL pulse_shape: got overlap %0d long %0d expected 0 0",
                     both_cnt, long_pulse_cnt);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rx          = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_baud_tolerance();
        test_pulse_shape();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
